// File: rtl/fb_scheduler_if.sv
// fb_scheduler_if: bundles the scanout, renderer, swap-control and frame-RAM
// signals of the framebuffer scheduler.
//   slave  : seen by fb_scheduler (takes requests, drives the RAM command)
//   master : seen by the surrounding logic (LCD path, renderer, RAM)
interface fb_scheduler_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 4
);
  logic              scan_req;
  logic [ADDR_W-1:0] scan_addr;
  logic              scan_valid;
  logic [DATA_W-1:0] scan_data;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              wr_err;
  logic              swap_req;
  logic              vblank_start;
  logic              swap_ack;
  logic              front_sel;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W:0]   mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  scan_req, scan_addr, wr_valid, wr_addr, wr_data,
           swap_req, vblank_start, mem_rdata,
    output scan_valid, scan_data, wr_ready, wr_err, swap_ack, front_sel,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output scan_req, scan_addr, wr_valid, wr_addr, wr_data,
           swap_req, vblank_start, mem_rdata,
    input  scan_valid, scan_data, wr_ready, wr_err, swap_ack, front_sel,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/fb_scheduler.sv
// fb_scheduler: double-buffered framebuffer controller on one single-port RAM.
// Scanout reads the front buffer with absolute priority (3-cycle fixed
// latency, one read per cycle); renderer writes go to the back buffer only in
// cycles with no scan request. Swaps requested by the renderer are committed
// at vblank_start so the panel never shows a partial frame.
// Ports:
//   pixel_clock / pixel_reset : clock, synchronous active-high reset
//   bus (slave)               : scan_*, wr_*, swap/vblank control, mem_*
module fb_scheduler #(
  parameter int FB_DEPTH = 384000,
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 4
) (
  input  logic         pixel_clock,
  input  logic         pixel_reset,
  fb_scheduler_if.slave bus
);

  localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(FB_DEPTH);

  typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_e;

  state_e            state_q, state_d;
  logic              front_sel_q, front_sel_d;
  logic              swap_ack_q, swap_ack_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              wr_err_q, wr_err_d;
  // Read pipeline: [0] = RAM command cycle, [1] = RAM data cycle.
  logic [1:0]        vld_pipe_q, vld_pipe_d;
  logic [1:0]        oor_pipe_q, oor_pipe_d;
  logic              scan_valid_q, scan_valid_d;
  logic [DATA_W-1:0] scan_data_q, scan_data_d;

  logic wr_ready, wr_go, scan_in, wr_in;

  assign wr_ready = !bus.scan_req && (state_q == IDLE) && !pixel_reset;
  assign wr_go    = bus.wr_valid && wr_ready;
  assign scan_in  = bus.scan_addr < DEPTH;
  assign wr_in    = bus.wr_addr < DEPTH;

  always_comb begin
    state_d      = state_q;
    front_sel_d  = front_sel_q;
    swap_ack_d   = 1'b0;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    wr_err_d     = 1'b0;
    vld_pipe_d   = {vld_pipe_q[0], bus.scan_req};
    oor_pipe_d   = {oor_pipe_q[0], !scan_in};
    scan_valid_d = vld_pipe_q[1];
    // Out-of-range reads never touched the RAM, so mem_rdata is stale: force 0.
    scan_data_d  = (vld_pipe_q[1] && !oor_pipe_q[1]) ? bus.mem_rdata : '0;

    // wr_go already implies no scan request, so this is the priority mux.
    if (bus.scan_req) begin
      if (scan_in) begin
        mem_en_d   = 1'b1;
        mem_addr_d = {front_sel_q, bus.scan_addr};
      end
    end else if (wr_go) begin
      if (wr_in) begin
        mem_en_d    = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = {~front_sel_q, bus.wr_addr};
        mem_wdata_d = bus.wr_data;
      end else begin
        wr_err_d = 1'b1;
      end
    end

    // vblank in IDLE and swap_req in PENDING are both dropped.
    case (state_q)
      IDLE:    if (bus.swap_req) state_d = PENDING;
      PENDING: if (bus.vblank_start) begin
        front_sel_d = ~front_sel_q;
        swap_ack_d  = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clock) begin
    if (pixel_reset) begin
      state_q      <= IDLE;
      front_sel_q  <= 1'b0;
      swap_ack_q   <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      wr_err_q     <= 1'b0;
      vld_pipe_q   <= '0;
      oor_pipe_q   <= '0;
      scan_valid_q <= 1'b0;
      scan_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      front_sel_q  <= front_sel_d;
      swap_ack_q   <= swap_ack_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      wr_err_q     <= wr_err_d;
      vld_pipe_q   <= vld_pipe_d;
      oor_pipe_q   <= oor_pipe_d;
      scan_valid_q <= scan_valid_d;
      scan_data_q  <= scan_data_d;
    end
  end

  assign bus.wr_ready   = wr_ready;
  assign bus.wr_err     = wr_err_q;
  assign bus.swap_ack   = swap_ack_q;
  assign bus.front_sel  = front_sel_q;
  assign bus.mem_en     = mem_en_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.scan_valid = scan_valid_q;
  assign bus.scan_data  = scan_data_q;

endmodule

// File: tb/tb_fb_scheduler.sv
// tb_fb_scheduler: directed scenarios plus a randomized run checked against
// a frame-level model (two image arrays, a front index and a pending flag).
module tb_fb_scheduler;
  localparam int FB_DEPTH = 384000;
  localparam int ADDR_W   = 19;
  localparam int DATA_W   = 4;
  localparam int WIN      = 1024;
  localparam int NCYC     = 3000;

  logic pixel_clock = 1'b0;
  logic pixel_reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  fb_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fb_scheduler #(.FB_DEPTH(FB_DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .pixel_clock (pixel_clock),
    .pixel_reset (pixel_reset),
    .bus         (bus)
  );

  always #5 pixel_clock = ~pixel_clock;

  // Frame RAM: 1-cycle read latency, write on mem_we.
  logic [DATA_W-1:0] ram [0:(1<<(ADDR_W+1))-1];
  always @(posedge pixel_clock)
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end

  task automatic cyc;
    @(posedge pixel_clock);
    #1;
  endtask

  task automatic idle_inputs;
    bus.scan_req = 0; bus.scan_addr = '0;
    bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.swap_req = 0; bus.vblank_start = 0;
  endtask

  task automatic scan_one(input logic [ADDR_W-1:0] a, output logic v,
                          output logic [DATA_W-1:0] d);
    cyc; bus.scan_req = 1; bus.scan_addr = a;
    cyc; bus.scan_req = 0;
    cyc;
    cyc; v = bus.scan_valid; d = bus.scan_data;
  endtask

  task automatic test_reset;
    pixel_reset = 1; bus.wr_valid = 1;
    cyc; cyc; #1;
    n_tests++;
    if ({bus.scan_valid, bus.scan_data, bus.wr_ready, bus.wr_err, bus.swap_ack,
         bus.front_sel, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: some output nonzero during reset (wr_ready=%b front_sel=%b)",
                         bus.wr_ready, bus.front_sel);
    end
    cyc; pixel_reset = 0; bus.wr_valid = 0; #1;
    n_tests++;
    if (bus.wr_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b want 1", bus.wr_ready);
    end
  endtask

  task automatic test_scan_stream;
    for (int t = 0; t < 16; t++) begin
      cyc;
      bus.scan_req = (t < 10); bus.scan_addr = ADDR_W'(t);
      #1;
      if (t < 10) begin
        n_tests++;
        if (bus.wr_ready !== 1'b0) begin
          n_fail++; $display("FAIL stream_wr_ready t=%0d: got %b want 0", t, bus.wr_ready);
        end
      end
      n_tests++;
      if (bus.scan_valid !== (t >= 3 && t <= 12) ||
          ((t >= 3 && t <= 12) && bus.scan_data !== DATA_W'(t - 3))) begin
        n_fail++; $display("FAIL stream_data t=%0d: got v=%b d=%0h want v=%b d=%0h",
                           t, bus.scan_valid, bus.scan_data, (t >= 3 && t <= 12), DATA_W'(t - 3));
      end
    end
    bus.scan_req = 0;
  endtask

  task automatic test_write;
    logic v; logic [DATA_W-1:0] d;
    cyc; bus.wr_valid = 1; bus.wr_addr = ADDR_W'(5); bus.wr_data = 4'hA; #1;
    n_tests++;
    if (bus.wr_ready !== 1'b1) begin
      n_fail++; $display("FAIL write_ready: got %b want 1", bus.wr_ready);
    end
    cyc; bus.wr_valid = 0;
    n_tests++;
    if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== {1'b1, ADDR_W'(5)} ||
        bus.mem_wdata !== 4'hA || bus.wr_err !== 1'b0) begin
      n_fail++; $display("FAIL write_cmd: got en=%b we=%b addr=%0h wd=%0h err=%b want 1 1 %0h a 0",
                         bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.wr_err, {1'b1, ADDR_W'(5)});
    end
    scan_one(ADDR_W'(5), v, d);
    n_tests++;
    if (v !== 1'b1 || d !== 4'h5) begin
      n_fail++; $display("FAIL write_front_unchanged: got v=%b d=%0h want 1 5", v, d);
    end
  endtask

  task automatic test_out_of_range;
    logic v; logic [DATA_W-1:0] d;
    cyc; bus.wr_valid = 1; bus.wr_addr = ADDR_W'(FB_DEPTH - 1); bus.wr_data = 4'h7;
    cyc; bus.wr_addr = ADDR_W'(FB_DEPTH); bus.wr_data = 4'hF;
    n_tests++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== {1'b1, ADDR_W'(FB_DEPTH - 1)} || bus.wr_err !== 1'b0) begin
      n_fail++; $display("FAIL oor_last_inrange: got we=%b addr=%0h err=%b want 1 %0h 0",
                         bus.mem_we, bus.mem_addr, bus.wr_err, {1'b1, ADDR_W'(FB_DEPTH - 1)});
    end
    cyc; bus.wr_valid = 0;
    n_tests++;
    if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0 || bus.wr_err !== 1'b1) begin
      n_fail++; $display("FAIL oor_write: got en=%b we=%b err=%b want 0 0 1", bus.mem_en, bus.mem_we, bus.wr_err);
    end
    cyc;
    n_tests++;
    if (bus.wr_err !== 1'b0) begin
      n_fail++; $display("FAIL oor_err_once: got %b want 0", bus.wr_err);
    end
    scan_one(ADDR_W'(400000), v, d);
    n_tests++;
    if (v !== 1'b1 || d !== 4'h0) begin
      n_fail++; $display("FAIL oor_scan: got v=%b d=%0h want 1 0", v, d);
    end
  endtask

  task automatic test_swap;
    logic v; logic [DATA_W-1:0] d;
    cyc; bus.swap_req = 1; #1;
    n_tests++;
    if (bus.wr_ready !== 1'b1) begin
      n_fail++; $display("FAIL swap_req_ready: got %b want 1", bus.wr_ready);
    end
    cyc; bus.swap_req = 0;
    for (int k = 0; k < 3; k++) begin
      bus.wr_valid = 1; bus.wr_addr = ADDR_W'(5); bus.wr_data = 4'h3; #1;
      n_tests++;
      if (bus.wr_ready !== 1'b0) begin
        n_fail++; $display("FAIL pending_ready k=%0d: got %b want 0", k, bus.wr_ready);
      end
      cyc;
      n_tests++;
      if (bus.mem_en !== 1'b0) begin
        n_fail++; $display("FAIL pending_no_write k=%0d: got en=%b want 0", k, bus.mem_en);
      end
    end
    bus.wr_valid = 0; bus.vblank_start = 1; #1;
    n_tests++;
    if (bus.wr_ready !== 1'b0 || bus.front_sel !== 1'b0 || bus.swap_ack !== 1'b0) begin
      n_fail++; $display("FAIL vblank_cycle: got ready=%b front=%b ack=%b want 0 0 0",
                         bus.wr_ready, bus.front_sel, bus.swap_ack);
    end
    cyc; bus.vblank_start = 0; #1;
    n_tests++;
    if (bus.front_sel !== 1'b1 || bus.swap_ack !== 1'b1 || bus.wr_ready !== 1'b1) begin
      n_fail++; $display("FAIL swap_commit: got front=%b ack=%b ready=%b want 1 1 1",
                         bus.front_sel, bus.swap_ack, bus.wr_ready);
    end
    cyc;
    n_tests++;
    if (bus.swap_ack !== 1'b0) begin
      n_fail++; $display("FAIL swap_ack_pulse: got %b want 0", bus.swap_ack);
    end
    scan_one(ADDR_W'(5), v, d);
    n_tests++;
    if (v !== 1'b1 || d !== 4'hA) begin
      n_fail++; $display("FAIL swap_new_front: got v=%b d=%0h want 1 a", v, d);
    end
  endtask

  task automatic test_swap_vblank_same;
    cyc; bus.swap_req = 1; bus.vblank_start = 1;
    cyc; bus.swap_req = 0; bus.vblank_start = 0; #1;
    n_tests++;
    if (bus.front_sel !== 1'b1 || bus.swap_ack !== 1'b0 || bus.wr_ready !== 1'b0) begin
      n_fail++; $display("FAIL same_cycle_no_swap: got front=%b ack=%b ready=%b want 1 0 0",
                         bus.front_sel, bus.swap_ack, bus.wr_ready);
    end
    cyc; cyc; bus.vblank_start = 1;
    cyc; bus.vblank_start = 0;
    n_tests++;
    if (bus.front_sel !== 1'b0 || bus.swap_ack !== 1'b1) begin
      n_fail++; $display("FAIL same_cycle_later_swap: got front=%b ack=%b want 0 1", bus.front_sel, bus.swap_ack);
    end
  endtask

  task automatic test_reset_mid;
    int bad;
    cyc; bus.swap_req = 1;
    cyc; bus.swap_req = 0; bus.vblank_start = 1;
    cyc; bus.vblank_start = 0;
    cyc; bus.scan_req = 1; bus.scan_addr = ADDR_W'(1);
    cyc; bus.scan_addr = ADDR_W'(2);
    cyc; bus.scan_req = 0; pixel_reset = 1;
    cyc; cyc; #1;
    n_tests++;
    if ({bus.scan_valid, bus.scan_data, bus.wr_ready, bus.wr_err, bus.swap_ack,
         bus.front_sel, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: got valid=%b front=%b en=%b ready=%b want all 0",
                         bus.scan_valid, bus.front_sel, bus.mem_en, bus.wr_ready);
    end
    pixel_reset = 0;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      cyc;
      if (bus.scan_valid !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL midreset_no_valid: got %0d stray valids want 0", bad);
    end
  endtask

  task automatic test_random;
    logic [DATA_W-1:0] img [2][WIN];
    bit                exp_sv [NCYC+4];
    logic [DATA_W-1:0] exp_sd [NCYC+4];
    bit                exp_en [NCYC+4];
    bit                exp_we [NCYC+4];
    logic [ADDR_W:0]   exp_ad [NCYC+4];
    logic [DATA_W-1:0] exp_wd [NCYC+4];
    bit                exp_err[NCYC+4];
    bit                exp_ack[NCYC+4];
    bit                exp_fr [NCYC+4];
    bit front, pending, rdy;
    bit sr, wv, sw, vb;
    logic [ADDR_W-1:0] sa, wa;
    logic [DATA_W-1:0] wd;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < WIN; i++) begin
        img[b][i] = DATA_W'($urandom);
        ram[(b << ADDR_W) + i] = img[b][i];
      end
    for (int c = 0; c < NCYC + 4; c++) begin
      exp_sv[c] = 0; exp_sd[c] = '0; exp_en[c] = 0; exp_we[c] = 0; exp_ad[c] = '0;
      exp_wd[c] = '0; exp_err[c] = 0; exp_ack[c] = 0; exp_fr[c] = 0;
    end
    front = 0; pending = 0;
    pixel_reset = 1; cyc; cyc;
    pixel_reset = 0; idle_inputs;
    for (int c = 0; c < NCYC; c++) begin
      cyc;
      n_tests++;
      if (bus.scan_valid !== exp_sv[c] || (exp_sv[c] && bus.scan_data !== exp_sd[c])) begin
        n_fail++; $display("FAIL rnd_scan c=%0d: got v=%b d=%0h want v=%b d=%0h",
                           c, bus.scan_valid, bus.scan_data, exp_sv[c], exp_sd[c]);
      end
      n_tests++;
      if (bus.mem_en !== exp_en[c] || bus.mem_we !== exp_we[c] ||
          (exp_en[c] && bus.mem_addr !== exp_ad[c]) ||
          (exp_we[c] && bus.mem_wdata !== exp_wd[c])) begin
        n_fail++; $display("FAIL rnd_mem c=%0d: got en=%b we=%b a=%0h wd=%0h want en=%b we=%b a=%0h wd=%0h",
                           c, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                           exp_en[c], exp_we[c], exp_ad[c], exp_wd[c]);
      end
      n_tests++;
      if (bus.front_sel !== exp_fr[c] || bus.swap_ack !== exp_ack[c] || bus.wr_err !== exp_err[c]) begin
        n_fail++; $display("FAIL rnd_ctrl c=%0d: got front=%b ack=%b err=%b want %b %b %b",
                           c, bus.front_sel, bus.swap_ack, bus.wr_err, exp_fr[c], exp_ack[c], exp_err[c]);
      end
      sr = ($urandom_range(1) == 0);
      wv = ($urandom_range(9) < 6);
      sw = ($urandom_range(15) == 0);
      vb = ($urandom_range(15) == 0);
      sa = ($urandom_range(7) == 0) ? ADDR_W'($urandom_range((1 << ADDR_W) - 1, FB_DEPTH))
                                    : ADDR_W'($urandom_range(WIN - 1));
      wa = ($urandom_range(7) == 0) ? ADDR_W'($urandom_range((1 << ADDR_W) - 1, FB_DEPTH))
                                    : ADDR_W'($urandom_range(WIN - 1));
      wd = DATA_W'($urandom);
      bus.scan_req = sr; bus.scan_addr = sa;
      bus.wr_valid = wv; bus.wr_addr = wa; bus.wr_data = wd;
      bus.swap_req = sw; bus.vblank_start = vb;
      #1;
      rdy = !sr && !pending;
      n_tests++;
      if (bus.wr_ready !== rdy) begin
        n_fail++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, bus.wr_ready, rdy);
      end
      if (sr) begin
        exp_sv[c+3] = 1;
        if (sa < FB_DEPTH) begin
          exp_en[c+1] = 1; exp_ad[c+1] = {front, sa};
          exp_sd[c+3] = img[front][sa[9:0]];
        end else exp_sd[c+3] = '0;
      end else if (wv && rdy) begin
        if (wa < FB_DEPTH) begin
          exp_en[c+1] = 1; exp_we[c+1] = 1; exp_ad[c+1] = {!front, wa}; exp_wd[c+1] = wd;
          img[!front][wa[9:0]] = wd;
        end else exp_err[c+1] = 1;
      end
      if (pending && vb) begin
        front = !front; pending = 0; exp_ack[c+1] = 1;
      end else if (!pending && sw) pending = 1;
      exp_fr[c+1] = front;
    end
    idle_inputs;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      ram[i] = DATA_W'(i);
      ram[i + (1 << ADDR_W)] = DATA_W'(i * 7 + 3);
    end
    test_reset;
    test_scan_stream;
    test_write;
    test_out_of_range;
    test_swap;
    test_swap_vblank_same;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
